d1s4439: RTL and testbench

//  - Three-input Boolean function unit: d = F(a,b,c), where F is a parameterised 8-entry truth table.
//  - The default F is 3-input majority.
//  - Provides a combinational result plus a registered copy for synchronous consumers.
//  - Provides a saturating count of cycles in which the registered result was 1.
//  - Leaf block used as a voting/decode cell inside the d1 datapath.

---
 rtl/d1_pkg.sv | 13 +
 rtl/d1s4439_satcnt.sv | 38 +++
 rtl/d1s4439.sv | 61 ++++++
 tb/tb_d1s4439.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/d1_pkg.sv
// Shared definitions for the d1 datapath leaf cells.
//   MAJ3_TT  : truth table of the 3-input majority function.
//   tt3_eval : returns the table entry selected by a 3-bit index.
package d1_pkg;

  // bit[i] of a table is F({a,b,c} == i); majority is 1 when two or more inputs are 1.
  localparam logic [7:0] MAJ3_TT = 8'b1110_1000;

  function automatic logic tt3_eval(input logic [7:0] tt, input logic [2:0] idx);
    return tt[idx];
  endfunction

endpackage : d1_pkg

// File: rtl/d1s4439_satcnt.sv
// Saturating up-counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count enable for this edge
//   cnt   : current count; holds at all-ones and never wraps
module d1s4439_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: the default assignment first means every path writes cnt_d, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : d1s4439_satcnt

// File: rtl/d1s4439.sv
// Three-input Boolean function cell: d = F(a,b,c), F given by an 8-entry truth
// table (majority by default), with a registered copy, a rising-edge pulse on the
// registered copy, and a saturating count of cycles where the registered copy is 1.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   a, b, c    : function inputs, {a,b,c} indexes the table (a is the MSB)
//   d          : combinational result, unaffected by reset
//   d_q        : d registered on the rising edge
//   rise       : one-cycle pulse on the first cycle d_q is 1 after being 0
//   ones_cnt   : saturating count of cycles with d_q == 1
module d1s4439
  import d1_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = MAJ3_TT,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             d,
  output logic             d_q,
  output logic             rise,
  output logic [CNT_W-1:0] ones_cnt
);

  logic dreg_q;
  logic rise_q;
  logic rise_d;

  assign d = tt3_eval(TRUTH_TABLE, {a, b, c});

  // The pulse is formed from the value about to be captured and the value
  // currently held, so it lines up with the first cycle d_q reads 1.
  assign rise_d = d & ~dreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreg_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      dreg_q <= d;
      rise_q <= rise_d;
    end
  end

  assign d_q  = dreg_q;
  assign rise = rise_q;

  // Counting on d at the edge makes the count track the value entering d_q.
  d1s4439_satcnt #(
    .CNT_W (CNT_W)
  ) u_satcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d),
    .cnt   (ones_cnt)
  );

endmodule : d1s4439

// File: tb/tb_d1s4439.sv
// Directed bench for d1s4439: majority instance, a 2-bit-counter instance and an
// XOR3 instance share inputs, clock and reset.
module tb_d1s4439;

  logic clk;
  logic rst_n;
  logic a, b, c;

  logic       maj_d, maj_dq, maj_rise;
  logic [7:0] maj_cnt;
  logic       sat_d, sat_dq, sat_rise;
  logic [1:0] sat_cnt;
  logic       xor_d, xor_dq, xor_rise;
  logic [7:0] xor_cnt;

  int n_checks = 0;
  int n_errors = 0;

  d1s4439 u_maj (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .d(maj_d), .d_q(maj_dq), .rise(maj_rise), .ones_cnt(maj_cnt)
  );

  d1s4439 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .d(sat_d), .d_q(sat_dq), .rise(sat_rise), .ones_cnt(sat_cnt)
  );

  d1s4439 #(.TRUTH_TABLE(8'b1001_0110)) u_xor (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .d(xor_d), .d_q(xor_dq), .rise(xor_rise), .ones_cnt(xor_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] v);
    {a, b, c} = v;
    #1;
  endtask

  int maj_tab[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
  int xor_tab[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
  int sat_tab[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst_n = 1'b1;
    {a, b, c} = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    check("rst_dq",   maj_dq,   0);
    check("rst_rise", maj_rise, 0);
    check("rst_cnt",  maj_cnt,  0);
    check("rst_sat",  sat_cnt,  0);

    // Combinational sweep, held in reset to show d ignores it.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = i[2:0];
      #1;
      check($sformatf("maj_d[%0d]", i), maj_d, maj_tab[i]);
      check($sformatf("xor_d[%0d]", i), xor_d, xor_tab[i]);
      #4;
    end

    {a, b, c} = 3'b000;
    rst_n = 1'b1;
    tick();
    check("idle_dq",   maj_dq,   0);
    check("idle_rise", maj_rise, 0);
    check("idle_cnt",  maj_cnt,  0);

    set_in(3'b011);
    tick();
    check("011_dq",   maj_dq,   1);
    check("011_rise", maj_rise, 1);
    check("011_cnt",  maj_cnt,  1);
    check("011_xdq",  xor_dq,   0);
    tick();
    check("011b_dq",   maj_dq,   1);
    check("011b_rise", maj_rise, 0);
    check("011b_cnt",  maj_cnt,  2);

    set_in(3'b000);
    check("000_d", maj_d, 0);
    tick();
    check("000_dq",   maj_dq,   0);
    check("000_rise", maj_rise, 0);
    check("000_cnt",  maj_cnt,  2);

    set_in(3'b110);
    tick();
    check("110_dq",   maj_dq,   1);
    check("110_rise", maj_rise, 1);
    check("110_cnt",  maj_cnt,  3);

    set_in(3'b111);
    tick();
    check("111a_cnt",  maj_cnt,  4);
    check("111a_rise", maj_rise, 0);
    tick();
    check("111b_cnt", maj_cnt, 5);
    check("111b_dq",  maj_dq,  1);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_dq",   maj_dq,   0);
    check("arst_rise", maj_rise, 0);
    check("arst_cnt",  maj_cnt,  0);
    check("arst_sat",  sat_cnt,  0);
    check("arst_xdq",  xor_dq,   0);
    check("arst_d111", maj_d,    1);
    set_in(3'b100);
    check("arst_d100",  maj_d, 0);
    check("arst_xd100", xor_d, 1);
    set_in(3'b111);
    rst_n = 1'b1;

    // Saturation of the 2-bit counter; rise fires on the first edge after release.
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("sat_cnt[%0d]", k),  sat_cnt,  sat_tab[k]);
      check($sformatf("maj_cnt[%0d]", k),  maj_cnt,  k + 1);
      check($sformatf("maj_rise[%0d]", k), maj_rise, (k == 0) ? 1 : 0);
      check($sformatf("xor_dq[%0d]", k),   xor_dq,   1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_d1s4439
